// File: rtl/baud_gen.sv
// Programmable baud-rate generator: divided clock, end-of-period tick and an
// oversample tick, with shadowed divisor updates applied on period boundaries.
module baud_gen #(
   parameter int DIV_W        = 16,
   parameter int DEFAULT_DIV  = 434,
   parameter int DEFAULT_HIGH = 232,
   parameter int OVS_LOG2     = 4
) (
   input  logic             clk_50M,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_in,
   input  logic [DIV_W-1:0] high_in,
   output logic             clk_out,
   output logic             tick,
   output logic             os_tick,
   output logic             div_pending
);

   localparam logic [DIV_W-1:0] L_DEF_DIV  = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] L_DEF_HIGH = DIV_W'(DEFAULT_HIGH);
   localparam logic [DIV_W-1:0] L_ONE      = DIV_W'(1);
   localparam logic [DIV_W-1:0] L_TWO      = DIV_W'(2);

   function automatic logic [DIV_W-1:0] f_os_div(input logic [DIV_W-1:0] i_div);
      logic [DIV_W-1:0] v_s;
      v_s = i_div >> OVS_LOG2;
      return (v_s == '0) ? L_ONE : v_s;
   endfunction

   logic [DIV_W-1:0] r_cnt, r_os_cnt;
   logic [DIV_W-1:0] r_div_act, r_high_act, r_os_div;
   logic [DIV_W-1:0] r_sh_div, r_sh_high;
   logic             r_pending, r_run;
   logic             r_clk_out, r_tick, r_os_tick;

   logic [DIV_W-1:0] w_sh_div, w_sh_high, w_ap_div, w_ap_high, w_ap_os;
   logic [DIV_W-1:0] w_div_n, w_high_n, w_os_div_n, w_cnt_n, w_os_cnt_n;
   logic             w_pend, w_wrap, w_period_start, w_apply, w_pend_n;
   logic             w_clk_n, w_tick_n, w_os_tick_n;

   always_comb begin
      // A div_load in the same cycle as an application point is forwarded,
      // so the freshly loaded value is what gets applied.
      w_sh_div  = div_load ? div_in  : r_sh_div;
      w_sh_high = div_load ? high_in : r_sh_high;
      w_pend    = div_load | r_pending;

      w_ap_div = (w_sh_div < L_TWO) ? L_TWO : w_sh_div;
      if (w_sh_high == '0)
         w_ap_high = w_ap_div >> 1;
      else if (w_sh_high >= w_ap_div)
         w_ap_high = w_ap_div - L_ONE;
      else
         w_ap_high = w_sh_high;
      w_ap_os = f_os_div(w_ap_div);

      w_wrap         = r_run && (r_cnt >= r_div_act - L_ONE);
      w_period_start = restart || !r_run || w_wrap;
      w_apply        = w_pend && (!en || w_period_start);
      w_pend_n       = w_pend && !w_apply;

      w_div_n    = w_apply ? w_ap_div  : r_div_act;
      w_high_n   = w_apply ? w_ap_high : r_high_act;
      w_os_div_n = w_apply ? w_ap_os   : r_os_div;

      w_cnt_n    = '0;
      w_os_cnt_n = '0;
      if (en && !w_period_start) begin
         w_cnt_n    = r_cnt + L_ONE;
         w_os_cnt_n = (r_os_cnt >= r_os_div - L_ONE) ? '0 : r_os_cnt + L_ONE;
      end

      // Outputs are registered from the next-cycle state so they are glitch-free.
      w_clk_n     = en && (w_cnt_n < w_high_n);
      w_tick_n    = en && (w_cnt_n == w_div_n - L_ONE);
      w_os_tick_n = en && !restart && (w_os_cnt_n == w_os_div_n - L_ONE);
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_os_cnt   <= '0;
         r_div_act  <= L_DEF_DIV;
         r_high_act <= L_DEF_HIGH;
         r_os_div   <= f_os_div(L_DEF_DIV);
         r_sh_div   <= L_DEF_DIV;
         r_sh_high  <= L_DEF_HIGH;
         r_pending  <= 1'b0;
         r_run      <= 1'b0;
         r_clk_out  <= 1'b0;
         r_tick     <= 1'b0;
         r_os_tick  <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_n;
         r_os_cnt   <= w_os_cnt_n;
         r_div_act  <= w_div_n;
         r_high_act <= w_high_n;
         r_os_div   <= w_os_div_n;
         r_sh_div   <= w_sh_div;
         r_sh_high  <= w_sh_high;
         r_pending  <= w_pend_n;
         r_run      <= en;
         r_clk_out  <= w_clk_n;
         r_tick     <= w_tick_n;
         r_os_tick  <= w_os_tick_n;
      end
   end

   assign clk_out     = r_clk_out;
   assign tick        = r_tick;
   assign os_tick     = r_os_tick;
   assign div_pending = r_pending;

endmodule
